fetch_stage: RTL

// - Instruction-fetch stage; sits between the program counter register and decode.
// - Drives the PC register's next-value input every cycle and fetches the word at the current PC from instruction memory.
// - Holds the IF/ID pipeline register and applies decode back-pressure (stall) and branch/jump redirects (flush).
// - No branch delay slot: a redirect discards every younger fetch.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/if_id_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 88 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the fetch stage
package cpu_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush/load/consume controls
// Ports: clock, reset (sync, active-high); flush, load, consume controls;
//        load_pc/load_instr captured on load; valid/pc/instr register contents.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        load,
    input  logic        consume,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    if_id_t q;

    // Flush beats load beats consume; a consume only drops the valid bit,
    // the NOP presentation of a dead slot is handled at the output.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '{valid: 1'b0, pc: RESET_PC, instr: NOP_INSTR};
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end else if (load) begin
            q <= '{valid: 1'b1, pc: load_pc, instr: load_instr};
        end else if (consume) begin
            q.valid <= 1'b0;
        end
    end

    assign valid = q.valid;
    assign pc    = q.pc;
    assign instr = q.valid ? q.instr : NOP_INSTR;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC steering, imem request FSM, IF/ID register
// Ports: clock, reset (sync, active-high); pc_value in / next_pc out to the PC register;
//        imem_req/imem_addr out, imem_rvalid/imem_rdata in; redirect_valid/redirect_target
//        from branch resolution; id_stall from decode; if_valid/if_pc/if_instr to decode.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_value,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_stall,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    fetch_state_t state;
    logic         slot_free;
    logic         issue;
    logic         capture;
    logic         consume;

    assign slot_free = !if_valid || !id_stall;

    // Request is combinational so a stall release issues in the same cycle.
    assign issue   = (state == IDLE) && slot_free && !redirect_valid && !reset;
    assign capture = (state == WAIT) && imem_rvalid && !redirect_valid;
    assign consume = if_valid && !id_stall;

    assign imem_req  = issue;
    assign imem_addr = pc_value;

    // The PC register has no enable: holding means feeding pc_value back.
    // The PC only advances on a capture, so pc_value is the fetched address
    // for the whole time a request is outstanding.
    always_comb begin
        next_pc = pc_value;
        if (redirect_valid) begin
            next_pc = redirect_target;
        end else if (capture) begin
            next_pc = pc_value + 32'd4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (issue) state <= WAIT;
                WAIT: begin
                    // Response alongside a redirect is simply discarded.
                    if (imem_rvalid)         state <= IDLE;
                    else if (redirect_valid) state <= DROP;
                end
                DROP: if (imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    if_id_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect_valid),
        .load       (capture),
        .consume    (consume),
        .load_pc    (pc_value),
        .load_instr (imem_rdata),
        .valid      (if_valid),
        .pc         (if_pc),
        .instr      (if_instr)
    );

endmodule
